// File: rtl/fetch_pkg.sv
// Shared state encoding, default widths and queue entry layout for the prefetching fetch stage.
package fetch_pkg;
    localparam int          ADDR_W_DEF   = 16;
    localparam int          INSTR_W_DEF  = 16;
    localparam int          INC_DEF      = 2;
    localparam int          DEPTH_DEF    = 4;
    localparam logic [15:0] RESET_PC_DEF = 16'h0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [INSTR_W_DEF-1:0] instr;
        logic [ADDR_W_DEF-1:0]  pc;
        logic [ADDR_W_DEF-1:0]  pc_inc;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; pointers carry one extra wrap bit so full and empty are distinct.
module fetch_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic                   i_flush,
    input  logic [WIDTH-1:0]       i_data,
    output logic [WIDTH-1:0]       o_data,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);
    localparam int                PTR_W    = $clog2(DEPTH);
    localparam int unsigned       FULL_I   = DEPTH;
    localparam logic [PTR_W:0]    FULL_CNT = FULL_I[PTR_W:0];

    logic [PTR_W:0]   r_wr_ptr;
    logic [PTR_W:0]   r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_do_push;
    logic             w_do_pop;

    assign o_count   = r_wr_ptr - r_rd_ptr;
    assign o_full    = (o_count == FULL_CNT);
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_data    = r_mem[r_rd_ptr[PTR_W-1:0]];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // NOTE: registers use <= so every flop samples the pre-edge value of its neighbours.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is not reset; the pointers alone decide which slots hold valid data.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) r_mem[r_wr_ptr[PTR_W-1:0]] <= i_data;
    end
endmodule

// File: rtl/fetch_queue.sv
// Prefetching fetch stage: PC register, single-outstanding imem handshake FSM and a decode-facing queue.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                INSTR_W  = INSTR_W_DEF,
    parameter int                INC      = INC_DEF,
    parameter int                DEPTH    = DEPTH_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               halt,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_done,
    input  logic [INSTR_W-1:0] imem_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [ADDR_W-1:0]  out_pc_inc,
    output logic               busy
);
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
        logic [ADDR_W-1:0]  pc_inc;
    } entry_t;

    localparam int               CNT_W      = $clog2(DEPTH) + 1;
    localparam int unsigned      ROOM_I     = DEPTH - 1;
    localparam logic [CNT_W-1:0] ROOM_LIMIT = ROOM_I[CNT_W-1:0];

    fetch_state_e      r_state;
    fetch_state_e      w_state_next;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_pc_next;
    logic [ADDR_W-1:0] w_pc_inc;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [CNT_W-1:0]  w_count;
    entry_t            w_push_entry;
    entry_t            w_head;

    assign w_pc_inc     = r_pc + ADDR_W'(INC);
    assign w_push       = (r_state == ST_REQ) && imem_done && !redirect;
    assign w_pop        = out_valid && out_ready;
    assign w_push_entry = '{instr: imem_data, pc: r_pc, pc_inc: w_pc_inc};

    fetch_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect),
        .i_data  (w_push_entry),
        .o_data  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // NOTE: every variable gets its default first, so no path leaves it unassigned (no latch).
    always_comb begin
        w_pc_next = r_pc;
        if (redirect)    w_pc_next = redirect_pc;
        else if (w_push) w_pc_next = w_pc_inc;
    end

    // Re-issue after a push counts the entry landing this cycle, keeping its slot reserved.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!halt && !redirect && !w_full) w_state_next = ST_REQ;
            end
            ST_REQ: begin
                if (redirect && imem_done)  w_state_next = halt ? ST_IDLE : ST_REQ;
                else if (redirect)          w_state_next = ST_DROP;
                else if (imem_done)         w_state_next = (!halt && (w_count < ROOM_LIMIT)) ? ST_REQ : ST_IDLE;
            end
            ST_DROP: begin
                if (imem_done) w_state_next = halt ? ST_IDLE : ST_REQ;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // The request address only moves when a new request starts, so DROP keeps the stale one.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_pc    <= RESET_PC;
            r_addr  <= RESET_PC;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            if (w_state_next == ST_REQ) r_addr <= w_pc_next;
        end
    end

    assign imem_req   = (r_state != ST_IDLE);
    assign imem_addr  = r_addr;
    assign out_valid  = !w_empty;
    assign out_instr  = w_empty ? '0 : w_head.instr;
    assign out_pc     = w_empty ? '0 : w_head.pc;
    assign out_pc_inc = w_empty ? '0 : w_head.pc_inc;
    assign busy       = (r_state != ST_IDLE) || !w_empty;
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: cycle table for stream/backpressure plus redirect, halt, wrap and reset sequences.
module tb_fetch_queue;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0;
    logic        halt = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_done = 1'b0;
    logic [15:0] imem_data = 16'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_instr;
    logic [15:0] out_pc;
    logic [15:0] out_pc_inc;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int mem_lat  = 1;
    int wait_cnt = 0;
    logic inject_done = 1'b0;
    fetch_entry_t acc_log[$];

    typedef struct {
        logic        rst_n;
        logic        ready;
        logic        exp_req;
        logic [15:0] exp_addr;
        logic        exp_valid;
        logic [15:0] exp_pc;
        logic        exp_busy;
    } vec_t;
    vec_t vecs[14];

    fetch_queue dut (
        .clk         (clk),
        .rst         (rst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_done   (imem_done),
        .imem_data   (imem_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .out_pc_inc  (out_pc_inc),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a ^ 16'hA5C3;
    endfunction

    // Memory model: answers mem_lat cycles after a request is seen; inject_done forces a stray response.
    always @(posedge clk) begin
        #1;
        imem_done = 1'b0;
        if (inject_done) begin
            imem_done = 1'b1;
            imem_data = 16'hDEAD;
            wait_cnt  = 0;
        end else if (imem_req) begin
            wait_cnt++;
            if (wait_cnt >= mem_lat) begin
                imem_done = 1'b1;
                imem_data = mem_word(imem_addr);
                wait_cnt  = 0;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    always @(posedge clk) begin
        if (rst && out_valid && out_ready)
            acc_log.push_back('{instr: out_instr, pc: out_pc, pc_inc: out_pc_inc});
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: expected event did not occur within the cycle budget", name);
    endtask

    task automatic check_log(input string name, input int idx, input logic [15:0] exp_pc);
        logic [15:0] exp_inc;
        exp_inc = exp_pc + 16'd2;
        if (idx >= acc_log.size()) begin
            timeout_fail(name);
        end else begin
            check({name, "_pc"},    acc_log[idx].pc,     exp_pc);
            check({name, "_inc"},   acc_log[idx].pc_inc, exp_inc);
            check({name, "_instr"}, acc_log[idx].instr,  mem_word(exp_pc));
        end
    endtask

    task automatic wait_log(input int n, input string name);
        int k = 0;
        while (acc_log.size() < n && k < 60) begin
            tick();
            k++;
        end
        if (acc_log.size() < n) timeout_fail(name);
    endtask

    task automatic do_reset(input int lat);
        rst         = 1'b0;
        redirect    = 1'b0;
        halt        = 1'b0;
        out_ready   = 1'b0;
        inject_done = 1'b0;
        mem_lat     = lat;
        repeat (2) tick();
    endtask

    initial begin
        int base;
        int n;
        int k;
        logic [15:0] e_pc;
        logic [15:0] e_inc;

        vecs[0]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000, 1'b1};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 16'h0002, 1'b1, 16'h0000, 1'b1};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 16'h0004, 1'b1, 16'h0002, 1'b1};
        vecs[4]  = '{1'b1, 1'b1, 1'b1, 16'h0006, 1'b1, 16'h0004, 1'b1};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 16'h0008, 1'b1, 16'h0004, 1'b1};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 16'h000A, 1'b1, 16'h0004, 1'b1};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0004, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0004, 1'b1};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0006, 1'b1};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 16'h000C, 1'b1, 16'h0008, 1'b1};
        vecs[11] = '{1'b1, 1'b1, 1'b1, 16'h000E, 1'b1, 16'h000A, 1'b1};
        vecs[12] = '{1'b1, 1'b1, 1'b1, 16'h0010, 1'b1, 16'h000C, 1'b1};
        vecs[13] = '{1'b1, 1'b0, 1'b1, 16'h0012, 1'b1, 16'h000C, 1'b1};

        // Reset state
        do_reset(1);
        check("rst_req",    imem_req,   1'b0);
        check("rst_valid",  out_valid,  1'b0);
        check("rst_busy",   busy,       1'b0);
        check("rst_instr",  out_instr,  16'h0);
        check("rst_pc",     out_pc,     16'h0);
        check("rst_pc_inc", out_pc_inc, 16'h0);

        // Stream, then backpressure filling exactly DEPTH entries, then drain
        for (int i = 0; i < 14; i++) begin
            rst       = vecs[i].rst_n;
            out_ready = vecs[i].ready;
            tick();
            check($sformatf("v%0d_req", i), imem_req, vecs[i].exp_req);
            if (vecs[i].exp_req) check($sformatf("v%0d_addr", i), imem_addr, vecs[i].exp_addr);
            check($sformatf("v%0d_valid", i), out_valid, vecs[i].exp_valid);
            if (vecs[i].exp_valid) begin
                e_inc = vecs[i].exp_pc + 16'd2;
                check($sformatf("v%0d_pc", i),    out_pc,     vecs[i].exp_pc);
                check($sformatf("v%0d_inc", i),   out_pc_inc, e_inc);
                check($sformatf("v%0d_instr", i), out_instr,  mem_word(vecs[i].exp_pc));
            end
            check($sformatf("v%0d_busy", i), busy, vecs[i].exp_busy);
        end

        // Redirect during a 3-cycle request: handshake completes, stale data dropped
        do_reset(3);
        out_ready = 1'b1;
        base = acc_log.size();
        rst = 1'b1;
        tick();
        redirect    = 1'b1;
        redirect_pc = 16'h0100;
        tick();
        redirect = 1'b0;
        check("rdm_hold_req",   imem_req,  1'b1);
        check("rdm_hold_addr",  imem_addr, 16'h0000);
        check("rdm_hold_valid", out_valid, 1'b0);
        tick();
        check("rdm_hold2_req",  imem_req,  1'b1);
        check("rdm_hold2_addr", imem_addr, 16'h0000);
        tick();
        check("rdm_new_req",   imem_req,  1'b1);
        check("rdm_new_addr",  imem_addr, 16'h0100);
        check("rdm_new_valid", out_valid, 1'b0);
        wait_log(base + 1, "rdm_first_timeout");
        check_log("rdm_first", base, 16'h0100);

        // Redirect coinciding with imem_done and a pop of the head
        do_reset(1);
        out_ready = 1'b1;
        base = acc_log.size();
        rst = 1'b1;
        k = 0;
        while (!(out_valid && out_pc == 16'h0004) && k < 20) begin
            tick();
            k++;
        end
        if (!(out_valid && out_pc == 16'h0004)) timeout_fail("rdc_fill_timeout");
        redirect    = 1'b1;
        redirect_pc = 16'h0200;
        tick();
        redirect = 1'b0;
        check("rdc_valid", out_valid, 1'b0);
        check("rdc_req",   imem_req,  1'b1);
        check("rdc_addr",  imem_addr, 16'h0200);
        wait_log(base + 4, "rdc_log_timeout");
        check_log("rdc_l0", base,     16'h0000);
        check_log("rdc_l1", base + 1, 16'h0002);
        check_log("rdc_l2", base + 2, 16'h0004);
        check_log("rdc_l3", base + 3, 16'h0200);

        // Wrap through 0xFFFF, halt drain, resume at next pc
        do_reset(1);
        out_ready = 1'b1;
        halt = 1'b1;
        rst  = 1'b1;
        repeat (2) tick();
        check("halt_idle_req", imem_req, 1'b0);
        redirect    = 1'b1;
        redirect_pc = 16'hFFFC;
        tick();
        redirect = 1'b0;
        base = acc_log.size();
        halt = 1'b0;
        tick();
        check("wrap_req",  imem_req,  1'b1);
        check("wrap_addr", imem_addr, 16'hFFFC);
        wait_log(base + 4, "wrap_log_timeout");
        check_log("wrap_l0", base,     16'hFFFC);
        check_log("wrap_l1", base + 1, 16'hFFFE);
        check_log("wrap_l2", base + 2, 16'h0000);
        halt = 1'b1;
        k = 0;
        while (busy && k < 30) begin
            tick();
            k++;
        end
        if (busy) timeout_fail("halt_drain_timeout");
        for (int i = 0; i < 4; i++) begin
            check($sformatf("halt_noreq%0d", i), imem_req, 1'b0);
            tick();
        end
        n = acc_log.size();
        for (int i = base; i < n; i++) begin
            e_pc = 16'hFFFC + 16'(2 * (i - base));
            check($sformatf("halt_seq%0d", i - base), acc_log[i].pc, e_pc);
        end
        e_pc = 16'hFFFC + 16'(2 * (n - base));
        halt = 1'b0;
        tick();
        check("resume_req",  imem_req,  1'b1);
        check("resume_addr", imem_addr, e_pc);
        wait_log(n + 1, "resume_log_timeout");
        check_log("resume_l0", n, e_pc);

        // Reset mid-request, late response must be ignored
        do_reset(3);
        out_ready = 1'b1;
        base = acc_log.size();
        rst = 1'b1;
        tick();
        check("rmr_req_before", imem_req, 1'b1);
        rst         = 1'b0;
        inject_done = 1'b1;
        tick();
        check("rmr_req",   imem_req,  1'b0);
        check("rmr_valid", out_valid, 1'b0);
        check("rmr_busy",  busy,      1'b0);
        check("rmr_pc",    out_pc,    16'h0);
        rst         = 1'b1;
        inject_done = 1'b0;
        tick();
        check("rmr_restart_req",   imem_req,  1'b1);
        check("rmr_restart_addr",  imem_addr, 16'h0000);
        check("rmr_restart_valid", out_valid, 1'b0);
        wait_log(base + 1, "rmr_log_timeout");
        check_log("rmr_first", base, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
Parametrised prefetching fetch stage. Generates sequential PCs and issues them to a variable-latency instruction memory over a req/done handshake. Buffers returned instructions with their PC and PC+INC in a DEPTH-entry queue, and presents them to decode over valid/ready. Supports redirect (branch/jump flush) and halt. Replaces the single-cycle fetch stage in front of decode.

Parameters:
ADDR_W, 16, PC/address width
INSTR_W, 16, instruction width
INC, 2, PC increment per instruction (bytes)
DEPTH, 4, queue entries; power of two, >= 2
RESET_PC, 0, PC loaded on reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; synchronous, active-low
redirect  in  1  flush and restart fetch at redirect_pc
redirect_pc  in  ADDR_W  new fetch address
halt  in  1  level; stops issuing new requests
imem_req  out  1  request valid; held until imem_done
imem_addr  out  ADDR_W  request address; stable while imem_req is high
imem_done  in  1  response valid for one cycle
imem_data  in  INSTR_W  instruction data, valid with imem_done
out_valid  out  1  queue head valid
out_ready  in  1  decode accepts the head
out_instr  out  INSTR_W  head instruction
out_pc  out  ADDR_W  head PC
out_pc_inc  out  ADDR_W  head PC + INC
busy  out  1  request outstanding or queue non-empty

Behaviour:
- Reset: when rst is 0 at a clk edge:
  - pc=RESET_PC, queue empty, state IDLE.
  - imem_req=0, out_valid=0, busy=0.
  - out_instr, out_pc and out_pc_inc read 0.
  - Reset overrides every other input, including mid-request. A response that arrives after reset is ignored, because the state is IDLE.
- Arithmetic: pc+INC is taken modulo 2^ADDR_W. 0xFFFE+2 wraps to 0x0000 with no flag.
- At most one request is outstanding.
- FSM states:
  - IDLE: imem_req=0. Goes to REQ when halt=0, redirect=0, and (count + 0) < DEPTH.
  - REQ: imem_req=1, imem_addr=pc.
    - On imem_done with no redirect: push {imem_data, pc, pc+INC}, set pc=pc+INC, then go to REQ if the issue condition still holds, else IDLE. Back-to-back issue gives one instruction per cycle with a 1-cycle memory.
    - On redirect without imem_done: go to DROP.
    - On redirect with imem_done in the same cycle: discard the data, go to REQ (or IDLE if halt=1).
  - DROP: imem_req=1 with the stale address until imem_done, so the handshake is never abandoned. The response is discarded, then go to REQ (or IDLE if halt=1).
- Space check: the request is issued only if count<DEPTH at issue time. The slot is implicitly reserved, so the push never overflows. A same-cycle pop frees a slot for the next issue decision one cycle later.
- Redirect (priority over everything except reset):
  - Queue cleared and pc=redirect_pc next cycle; out_valid=0 the cycle after redirect.
  - A pop in the redirect cycle (out_valid&&out_ready) still counts as consumed.
  - A redirect arriving in DROP stays in DROP and updates pc.
- Queue behaviour:
  - Push and pop in the same cycle leave count unchanged.
  - Push into an empty queue is visible on out_valid the next cycle (registered, no bypass).
  - Pop from an empty queue is ignored.
  - Outputs hold stable while out_valid=1 and out_ready=0.
- Halt: no new issue. An outstanding request completes and its data is pushed. The queue keeps draining. Clearing halt resumes at the current pc.
- busy = (state!=IDLE) || count!=0.

Decomposition:
- Package fetch_pkg:
  - FSM state encoding: IDLE=2'd0, REQ=2'd1, DROP=2'd2.
  - Default widths, INC and RESET_PC.
  - Queue entry struct {instr, pc, pc_inc}.
- Sub-module fetch_fifo (WIDTH, DEPTH): sync FIFO with push, pop, flush, count, full and empty.
  - Pointers use log2(DEPTH)+1 bits.
  - Flush has priority over push.
- The top level holds the PC register, FSM and issue logic.

Test Plan:
- Reset and stream: release rst, memory responds 1 cycle after req, out_ready=1 -> out_pc reads 0x0000, 0x0002, 0x0004…, one per cycle after fill; out_pc_inc=out_pc+2.
- Backpressure: out_ready=0, DEPTH=4 -> exactly 4 entries pushed and imem_req then drops. Setting out_ready=1 pops 0,2,4,6 in order with no loss or duplicates.
- Redirect mid-request: memory latency 3, redirect to 0x0100 in cycle 1 of the request -> imem_req held until done, stale data not delivered, next imem_addr=0x0100, first out_pc=0x0100.
- Redirect coincident with imem_done, plus a queue pop in the same cycle -> popped entry consumed once, arriving data dropped, queue empty, next fetch at redirect_pc.
- Wrap and halt: RESET_PC=0xFFFC -> out_pc 0xFFFC, 0xFFFE, 0x0000. Assert halt -> no new req after the outstanding one, busy falls to 0 once drained. Deassert halt -> resumes at the next pc.
- Reset mid-request (rst=0 while imem_req=1) -> next cycle imem_req=0, out_valid=0, pc=RESET_PC, late imem_done ignored.
